// File: rtl/net_rtp_pkg.sv
// RTP constants shared by the receive depacketizer and the transmit packetizer.
// Byte offsets are counted from the first byte of the UDP payload.
package net_rtp_pkg;

  localparam int          RTP_HEADER_LENGTH = 12;
  localparam logic [1:0]  RTP_VERSION       = 2'd2;
  localparam int          RTP_OFS_FLAGS     = 0;
  localparam int          RTP_OFS_PT        = 1;
  localparam int          RTP_OFS_SEQ       = 2;
  localparam int          RTP_OFS_TS        = 4;
  localparam int          RTP_OFS_SSRC      = 8;
  localparam logic [31:0] RTP_SSRC_DEFAULT  = 32'h12345678;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rtp_sample_fifo.sv
// Sample FIFO whose writes stay invisible to the reader until committed; a
// rollback rewinds the tentative write pointer to the last committed one.
module rtp_sample_fifo #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic [AW:0]   level,
  output logic [AW:0]   free
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [15:0] mem [0:(1<<AW)-1];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] cwr_ptr_q, cwr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign level   = cwr_ptr_q - rd_ptr_q;
  // Free space is judged against the tentative pointer so an in-flight packet
  // can never overwrite unread samples.
  assign free    = DEPTH - (wr_ptr_q - rd_ptr_q);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cwr_ptr_d = cwr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (rollback)
      wr_ptr_d = cwr_ptr_q;
    else if (wr_en)
      wr_ptr_d = wr_ptr_q + ONE;
    if (commit)
      cwr_ptr_d = wr_ptr_d;
    if (rd_en && (level != '0))
      rd_ptr_d = rd_ptr_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      cwr_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cwr_ptr_q <= cwr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// Receives RTP-over-UDP byte streams, validates the header and commits whole
// packets of 16-bit samples into a FIFO that a DAC drains one sample per request.
module rtp_rx_depacketizer
  import net_rtp_pkg::*;
#(
  parameter int          UDP_LENGTH  = 960,
  parameter logic [6:0]  PT_EXPECT   = 7'd0,
  parameter logic [31:0] SSRC_EXPECT = RTP_SSRC_DEFAULT,
  parameter bit          CHECK_SSRC  = 1'b1,
  parameter int          FIFO_AW     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                udp_rec_data_valid,
  input  logic [7:0]          udp_rec_rdata,
  input  logic [15:0]         udp_rec_data_length,
  input  logic                dac_req,
  output logic signed [15:0]  dac_data,
  output logic                dac_valid,
  output logic                underflow,
  output logic [FIFO_AW:0]    fifo_level,
  output logic [15:0]         pkt_ok_cnt,
  output logic [15:0]         pkt_drop_cnt,
  output logic [15:0]         seq_gap_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [15:0] LEN      = 16'(UDP_LENGTH);
  localparam logic [15:0] LAST_IDX = 16'(UDP_LENGTH - 1);
  localparam logic [15:0] B_PT     = 16'(RTP_OFS_PT);
  localparam logic [15:0] B_SEQ    = 16'(RTP_OFS_SEQ);
  localparam logic [15:0] B_SSRC   = 16'(RTP_OFS_SSRC);
  localparam logic [15:0] B_HLAST  = 16'(RTP_HEADER_LENGTH - 1);
  localparam int          PKT_SAMPLES_I = (UDP_LENGTH - RTP_HEADER_LENGTH) / 2;
  localparam logic [FIFO_AW:0] PKT_SAMPLES = PKT_SAMPLES_I[FIFO_AW:0];

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] seq_q, seq_d;
  logic [23:0] ssrc_q, ssrc_d;
  logic [15:0] last_seq_q, last_seq_d;
  logic        have_last_q, have_last_d;
  logic [15:0] ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d, gap_cnt_q, gap_cnt_d;
  logic signed [15:0] dac_data_q, dac_data_d;
  logic        dac_valid_q, dac_valid_d, underflow_q, underflow_d;
  logic        valid_prev_q;
  logic        hdr_fail;
  logic [15:0] seq_next;

  logic              fifo_wr, fifo_commit, fifo_rollback, fifo_rd;
  logic [15:0]       fifo_rd_data;
  logic [FIFO_AW:0]  fifo_free;

  rtp_sample_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  ({hi_q, udp_rec_rdata}),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rd_data),
    .level    (fifo_level),
    .free     (fifo_free)
  );

  assign seq_next = last_seq_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    seq_d         = seq_q;
    ssrc_d        = ssrc_q;
    last_seq_d    = last_seq_q;
    have_last_d   = have_last_q;
    ok_cnt_d      = ok_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    hdr_fail      = 1'b0;
    fifo_wr       = 1'b0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a rising edge of valid starts a packet (byte 0 is this cycle).
        if (udp_rec_data_valid && !valid_prev_q) begin
          cnt_d = 16'd1;
          if ((udp_rec_data_length != LEN) || (udp_rec_rdata[7:6] != RTP_VERSION)) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            state_d    = ST_DISCARD;
          end else begin
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (!udp_rec_data_valid) begin
          drop_cnt_d = sat_inc16(drop_cnt_q);
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q == B_PT) && (udp_rec_rdata[6:0] != PT_EXPECT))
            hdr_fail = 1'b1;
          if (cnt_q == B_SEQ)
            seq_d[15:8] = udp_rec_rdata;
          if (cnt_q == B_SEQ + 16'd1)
            seq_d[7:0] = udp_rec_rdata;
          if ((cnt_q >= B_SSRC) && (cnt_q < B_HLAST))
            ssrc_d = {ssrc_q[15:0], udp_rec_rdata};
          if (cnt_q == B_HLAST) begin
            if (CHECK_SSRC && ({ssrc_q, udp_rec_rdata} != SSRC_EXPECT))
              hdr_fail = 1'b1;
            if (fifo_free < PKT_SAMPLES)
              hdr_fail = 1'b1;
          end
          if (hdr_fail) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            state_d    = ST_DISCARD;
          end else if (cnt_q == B_HLAST) begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          fifo_rollback = 1'b1;
          drop_cnt_d    = sat_inc16(drop_cnt_q);
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          // Payload starts at an even offset: even bytes are sample high halves.
          if (!cnt_q[0])
            hi_d = udp_rec_rdata;
          else
            fifo_wr = 1'b1;
          if (cnt_q == LAST_IDX) begin
            fifo_commit = 1'b1;
            ok_cnt_d    = sat_inc16(ok_cnt_q);
            if (have_last_q && (seq_q != seq_next))
              gap_cnt_d = sat_inc16(gap_cnt_q);
            last_seq_d  = seq_q;
            have_last_d = 1'b1;
            state_d     = ST_DISCARD;
          end
        end
      end
      default: begin
        if (!udp_rec_data_valid)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    underflow_d = 1'b0;
    fifo_rd     = 1'b0;
    if (dac_req) begin
      dac_valid_d = 1'b1;
      if (fifo_level != '0) begin
        fifo_rd    = 1'b1;
        dac_data_d = $signed(fifo_rd_data);
      end else begin
        dac_data_d  = '0;
        underflow_d = 1'b1;
      end
    end
  end

  // Sampled even during reset so a packet already in flight at release is ignored.
  always_ff @(posedge clk) begin
    valid_prev_q <= udp_rec_data_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      seq_q       <= '0;
      ssrc_q      <= '0;
      last_seq_q  <= '0;
      have_last_q <= 1'b0;
      ok_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      seq_q       <= seq_d;
      ssrc_q      <= ssrc_d;
      last_seq_q  <= last_seq_d;
      have_last_q <= have_last_d;
      ok_cnt_q    <= ok_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign dac_data     = dac_data_q;
  assign dac_valid    = dac_valid_q;
  assign underflow    = underflow_q;
  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign seq_gap_cnt  = gap_cnt_q;

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Bench for rtp_rx_depacketizer: directed scenarios plus randomized packets
// compared against a packet-level model (accept/drop rules and a sample queue).
`timescale 1ns/1ps
module tb_rtp_rx_depacketizer;

  localparam int UDP_LEN = 960;
  localparam int NSAMP   = (UDP_LEN - 12) / 2;
  localparam int DEPTH   = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [7:0] rdata = '0;
  logic [15:0] len_in = '0;
  logic dac_req = 1'b0;

  logic signed [15:0] dac_data, ns_dac_data;
  logic dac_valid, underflow, ns_dac_valid, ns_underflow;
  logic [10:0] fifo_level, ns_fifo_level;
  logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt;
  logic [15:0] ns_pkt_ok_cnt, ns_pkt_drop_cnt, ns_seq_gap_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int m_ok, m_drop, m_gap;
  logic [15:0] m_last_seq;
  bit m_have_last;

  logic [7:0] pkt_b[$];
  logic [15:0] cap_data;
  logic cap_valid, cap_uf;

  always #5 clk = ~clk;

  rtp_rx_depacketizer u_dut (
    .clk(clk), .rst_n(rst_n), .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
    .udp_rec_data_length(len_in), .dac_req(dac_req), .dac_data(dac_data),
    .dac_valid(dac_valid), .underflow(underflow), .fifo_level(fifo_level),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt), .seq_gap_cnt(seq_gap_cnt)
  );

  rtp_rx_depacketizer #(.CHECK_SSRC(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .udp_rec_data_valid(valid), .udp_rec_rdata(rdata),
    .udp_rec_data_length(len_in), .dac_req(dac_req), .dac_data(ns_dac_data),
    .dac_valid(ns_dac_valid), .underflow(ns_underflow), .fifo_level(ns_fifo_level),
    .pkt_ok_cnt(ns_pkt_ok_cnt), .pkt_drop_cnt(ns_pkt_drop_cnt), .seq_gap_cnt(ns_seq_gap_cnt)
  );

  // ---------------- model ----------------
  task automatic model_reset();
    exp_q.delete();
    m_ok = 0; m_drop = 0; m_gap = 0;
    m_last_seq = '0; m_have_last = 1'b0;
  endtask

  task automatic model_pkt(input int n, input logic [15:0] len_field);
    logic [31:0] ssrc;
    logic [15:0] seq;
    logic [7:0] b0, b1;
    bit accept;
    b0 = pkt_b[0];
    b1 = pkt_b[1];
    seq  = {pkt_b[2], pkt_b[3]};
    ssrc = {pkt_b[8], pkt_b[9], pkt_b[10], pkt_b[11]};
    accept = (len_field == 16'(UDP_LEN)) && (n >= UDP_LEN) && (b0[7:6] == 2'd2) &&
             (b1[6:0] == 7'd0) && (ssrc == 32'h12345678) && (DEPTH - exp_q.size() >= NSAMP);
    if (!accept) begin
      m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
    end else begin
      for (int i = 0; i < NSAMP; i++)
        exp_q.push_back({pkt_b[12 + 2*i], pkt_b[13 + 2*i]});
      m_ok = (m_ok == 65535) ? m_ok : m_ok + 1;
      if (m_have_last && (seq != 16'(m_last_seq + 16'd1)))
        m_gap = (m_gap == 65535) ? m_gap : m_gap + 1;
      m_last_seq = seq;
      m_have_last = 1'b1;
    end
  endtask

  task automatic model_read(output logic [15:0] e, output logic eu);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); eu = 1'b0;
    end else begin
      e = '0; eu = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; dac_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic build_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] seq,
                           input logic [31:0] ssrc, input bit rand_samp, input logic [15:0] base,
                           input int extra);
    logic [15:0] s;
    pkt_b.delete();
    pkt_b.push_back(b0);
    pkt_b.push_back(b1);
    pkt_b.push_back(seq[15:8]);
    pkt_b.push_back(seq[7:0]);
    for (int i = 0; i < 4; i++) pkt_b.push_back(8'($urandom));
    pkt_b.push_back(ssrc[31:24]);
    pkt_b.push_back(ssrc[23:16]);
    pkt_b.push_back(ssrc[15:8]);
    pkt_b.push_back(ssrc[7:0]);
    for (int i = 0; i < NSAMP; i++) begin
      s = rand_samp ? 16'($urandom) : base + 16'(i);
      pkt_b.push_back(s[15:8]);
      pkt_b.push_back(s[7:0]);
    end
    for (int i = 0; i < extra; i++) pkt_b.push_back(8'($urandom));
  endtask

  task automatic drive_pkt(input int n, input logic [15:0] len_field, input int pop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b1; rdata = pkt_b[i]; len_in = len_field; dac_req = (i == pop_at);
    end
    @(negedge clk);
    cap_data = dac_data; cap_valid = dac_valid; cap_uf = underflow;
    valid = 1'b0; dac_req = 1'b0; rdata = '0;
    @(negedge clk);
  endtask

  task automatic dac_read(output logic [15:0] d, output logic v, output logic uf);
    @(negedge clk);
    dac_req = 1'b1;
    @(negedge clk);
    dac_req = 1'b0;
    d = dac_data; v = dac_valid; uf = underflow;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (dac_data !== '0) begin failures++; $display("FAIL reset_dac_data: got %h expected 0", dac_data); end
    checks++; if (dac_valid !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_pulses: valid=%b underflow=%b expected 0 0", dac_valid, underflow); end
    checks++; if (pkt_ok_cnt !== '0 || pkt_drop_cnt !== '0 || seq_gap_cnt !== '0) begin failures++; $display("FAIL reset_counters: ok=%0d drop=%0d gap=%0d expected 0 0 0", pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt); end
  endtask

  task automatic test_valid_packet();
    logic [15:0] d, e; logic v, uf, eu;
    do_reset();
    build_pkt(8'h80, 8'h80, 16'd5, 32'h12345678, 1'b0, 16'h0001, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    checks++; if (fifo_level !== 11'(exp_q.size())) begin failures++; $display("FAIL valid_level: got %0d expected %0d", fifo_level, exp_q.size()); end
    checks++; if (pkt_ok_cnt !== 16'(m_ok)) begin failures++; $display("FAIL valid_ok_cnt: got %0d expected %0d", pkt_ok_cnt, m_ok); end
    e = '0;
    for (int i = 0; i < NSAMP; i++) begin
      dac_read(d, v, uf); model_read(e, eu);
      checks++;
      if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL valid_read_%0d: data=%h valid=%b uf=%b expected %h 1 %b", i, d, v, uf, e, eu); end
    end
    @(negedge clk);
    checks++; if (dac_data !== e || dac_valid !== 1'b0) begin failures++; $display("FAIL hold_data: data=%h valid=%b expected %h 0", dac_data, dac_valid, e); end
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL valid_drained: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_bad_packets();
    do_reset();
    build_pkt(8'h80, 8'h80, 16'd1, 32'hDEADBEEF, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    build_pkt(8'h80, 8'h80, 16'd2, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(958, 16'd958, -1);
    model_pkt(958, 16'd958);
    checks++; if (fifo_level !== 11'(exp_q.size())) begin failures++; $display("FAIL bad_level: got %0d expected %0d", fifo_level, exp_q.size()); end
    checks++; if (pkt_drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL bad_drop_cnt: got %0d expected %0d", pkt_drop_cnt, m_drop); end
    checks++; if (ns_fifo_level !== 11'(NSAMP) || ns_pkt_ok_cnt !== 16'd1 || ns_pkt_drop_cnt !== 16'd1) begin failures++; $display("FAIL nossrc_accept: level=%0d ok=%0d drop=%0d expected %0d 1 1", ns_fifo_level, ns_pkt_ok_cnt, ns_pkt_drop_cnt, NSAMP); end
  endtask

  task automatic test_truncation();
    logic [15:0] d, e; logic v, uf, eu;
    do_reset();
    build_pkt(8'h80, 8'h00, 16'd7, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(500, 16'(UDP_LEN), -1);
    model_pkt(500, 16'(UDP_LEN));
    checks++; if (fifo_level !== '0 || pkt_drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL trunc_drop: level=%0d drop=%0d expected 0 %0d", fifo_level, pkt_drop_cnt, m_drop); end
    build_pkt(8'h80, 8'h00, 16'd8, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    checks++; if (fifo_level !== 11'(exp_q.size()) || pkt_ok_cnt !== 16'(m_ok)) begin failures++; $display("FAIL trunc_next: level=%0d ok=%0d expected %0d %0d", fifo_level, pkt_ok_cnt, exp_q.size(), m_ok); end
    for (int i = 0; i < NSAMP; i++) begin
      dac_read(d, v, uf); model_read(e, eu);
      checks++;
      if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL trunc_read_%0d: data=%h valid=%b uf=%b expected %h 1 %b", i, d, v, uf, e, eu); end
    end
  endtask

  task automatic test_seq_wrap();
    logic [15:0] seqs[3];
    logic [15:0] d, e; logic v, uf, eu;
    seqs[0] = 16'hFFFF; seqs[1] = 16'h0000; seqs[2] = 16'h0002;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      build_pkt(8'h80, 8'h00, seqs[p], 32'h12345678, 1'b1, 16'h0, 0);
      drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
      model_pkt(UDP_LEN, 16'(UDP_LEN));
      checks++; if (seq_gap_cnt !== 16'(m_gap) || pkt_ok_cnt !== 16'(m_ok)) begin failures++; $display("FAIL seq_gap_%0d: gap=%0d ok=%0d expected %0d %0d", p, seq_gap_cnt, pkt_ok_cnt, m_gap, m_ok); end
      for (int i = 0; i < NSAMP; i++) begin
        dac_read(d, v, uf); model_read(e, eu);
        checks++;
        if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL seq_read_%0d_%0d: data=%h uf=%b expected %h %b", p, i, d, uf, e, eu); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d, e; logic v, uf, eu;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      build_pkt(8'h80, 8'h80, 16'(100 + p), 32'h12345678, 1'b1, 16'h0, 0);
      drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
      model_pkt(UDP_LEN, 16'(UDP_LEN));
    end
    checks++; if (fifo_level !== 11'(exp_q.size()) || pkt_ok_cnt !== 16'(m_ok) || pkt_drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL overflow_drop: level=%0d ok=%0d drop=%0d expected %0d %0d %0d", fifo_level, pkt_ok_cnt, pkt_drop_cnt, exp_q.size(), m_ok, m_drop); end
    for (int i = 0; i < 2*NSAMP + 1; i++) begin
      dac_read(d, v, uf); model_read(e, eu);
      checks++;
      if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL overflow_read_%0d: data=%h valid=%b uf=%b expected %h 1 %b", i, d, v, uf, e, eu); end
    end
    @(negedge clk);
    checks++; if (dac_valid !== 1'b0 || underflow !== 1'b0 || dac_data !== '0) begin failures++; $display("FAIL underflow_pulse: valid=%b uf=%b data=%h expected 0 0 0", dac_valid, underflow, dac_data); end
  endtask

  task automatic test_commit_pop();
    logic [15:0] d, e; logic v, uf, eu;
    do_reset();
    build_pkt(8'h80, 8'h00, 16'd10, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    build_pkt(8'h80, 8'h00, 16'd11, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), UDP_LEN - 1);
    model_read(e, eu);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    checks++; if (cap_data !== e || cap_valid !== 1'b1 || cap_uf !== eu) begin failures++; $display("FAIL commit_pop_data: data=%h valid=%b uf=%b expected %h 1 %b", cap_data, cap_valid, cap_uf, e, eu); end
    checks++; if (fifo_level !== 11'(exp_q.size())) begin failures++; $display("FAIL commit_pop_level: got %0d expected %0d", fifo_level, exp_q.size()); end
    for (int i = 0; i < 2*NSAMP - 1; i++) begin
      dac_read(d, v, uf); model_read(e, eu);
      checks++;
      if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL commit_pop_read_%0d: data=%h uf=%b expected %h %b", i, d, uf, e, eu); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, e; logic v, uf, eu;
    do_reset();
    build_pkt(8'h80, 8'h00, 16'd20, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    dac_read(d, v, uf); model_read(e, eu);
    checks++; if (d !== e) begin failures++; $display("FAIL mid_pre_read: data=%h expected %h", d, e); end
    build_pkt(8'h80, 8'h00, 16'd21, 32'h12345678, 1'b1, 16'h0, 0);
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      valid = 1'b1; rdata = pkt_b[i]; len_in = 16'(UDP_LEN);
      if (i == 600) rst_n = 1'b0;
      if (i == 604) rst_n = 1'b1;
    end
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    model_reset();
    checks++; if (fifo_level !== '0 || dac_data !== '0 || dac_valid !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL mid_outputs: level=%0d data=%h valid=%b uf=%b expected 0 0 0 0", fifo_level, dac_data, dac_valid, underflow); end
    checks++; if (pkt_ok_cnt !== '0 || pkt_drop_cnt !== '0 || seq_gap_cnt !== '0) begin failures++; $display("FAIL mid_counters: ok=%0d drop=%0d gap=%0d expected 0 0 0", pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt); end
    build_pkt(8'h80, 8'h00, 16'd99, 32'h12345678, 1'b1, 16'h0, 0);
    drive_pkt(UDP_LEN, 16'(UDP_LEN), -1);
    model_pkt(UDP_LEN, 16'(UDP_LEN));
    checks++; if (fifo_level !== 11'(exp_q.size()) || pkt_ok_cnt !== 16'(m_ok)) begin failures++; $display("FAIL mid_after: level=%0d ok=%0d expected %0d %0d", fifo_level, pkt_ok_cnt, exp_q.size(), m_ok); end
    for (int i = 0; i < NSAMP; i++) begin
      dac_read(d, v, uf); model_read(e, eu);
      checks++;
      if (d !== e || uf !== eu) begin failures++; $display("FAIL mid_read_%0d: data=%h uf=%b expected %h %b", i, d, uf, e, eu); end
    end
  endtask

  task automatic test_random();
    logic [15:0] d, e; logic v, uf, eu;
    logic [7:0] b0, b1;
    logic [15:0] seq, len_f;
    logic [31:0] ssrc;
    int kind, n, extra, nreads;
    do_reset();
    seq = 16'($urandom);
    for (int p = 0; p < 10; p++) begin
      kind = $urandom_range(0, 6);
      b0 = {2'b10, 6'($urandom)};
      b1 = {1'($urandom), 7'd0};
      seq = ($urandom_range(0, 1) == 1) ? seq + 16'd1 : 16'($urandom);
      ssrc = 32'h12345678;
      len_f = 16'(UDP_LEN);
      n = UDP_LEN;
      extra = 0;
      case (kind)
        1: b0 = {2'($urandom_range(0, 1)), 6'($urandom)};
        2: b1 = {1'b0, 7'($urandom_range(1, 127))};
        3: ssrc = 32'h12345678 ^ (32'd1 << $urandom_range(0, 31));
        4: len_f = 16'($urandom_range(13, 959));
        5: n = $urandom_range(1, UDP_LEN - 1);
        6: extra = $urandom_range(1, 8);
        default: ;
      endcase
      n = n + extra;
      build_pkt(b0, b1, seq, ssrc, 1'b1, 16'h0, extra);
      drive_pkt(n, len_f, -1);
      model_pkt(n, len_f);
      checks++; if (fifo_level !== 11'(exp_q.size())) begin failures++; $display("FAIL rand_level_%0d: got %0d expected %0d (kind %0d)", p, fifo_level, exp_q.size(), kind); end
      checks++; if (pkt_ok_cnt !== 16'(m_ok) || pkt_drop_cnt !== 16'(m_drop) || seq_gap_cnt !== 16'(m_gap)) begin failures++; $display("FAIL rand_counters_%0d: ok=%0d drop=%0d gap=%0d expected %0d %0d %0d", p, pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, m_ok, m_drop, m_gap); end
      nreads = $urandom_range(0, 500);
      for (int i = 0; i < nreads; i++) begin
        dac_read(d, v, uf); model_read(e, eu);
        checks++;
        if (d !== e || v !== 1'b1 || uf !== eu) begin failures++; $display("FAIL rand_read_%0d_%0d: data=%h valid=%b uf=%b expected %h 1 %b", p, i, d, v, uf, e, eu); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_valid_packet();
    test_bad_packets();
    test_truncation();
    test_seq_wrap();
    test_overflow();
    test_commit_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtp_rx_depacketizer.md
RTP_RX_DEPACKETIZER -- requirements
Module: rtp_rx_depacketizer

Interface
REQ-001 SHALL have parameter UDP_LENGTH, default 960, meaning expected UDP payload bytes per packet, RTP header included.
REQ-002 SHALL have parameter PT_EXPECT, default 7'd0, meaning accepted RTP payload type.
REQ-003 SHALL have parameter SSRC_EXPECT, default 32'h12345678, meaning accepted source id.
REQ-004 SHALL have parameter CHECK_SSRC, default 1, meaning SSRC mismatch drops the packet (0 = ignore SSRC).
REQ-005 SHALL have parameter FIFO_AW, default 10, meaning sample FIFO depth 2**FIFO_AW.
REQ-006 SHALL have ports: clk in 1, system clock; rst_n in 1, reset.
REQ-007 SHALL have ports: udp_rec_data_valid in 1, one byte per cycle while high; udp_rec_rdata in 8, byte; udp_rec_data_length in 16, packet length, stable while valid.
REQ-008 SHALL have ports: dac_req in 1, one-cycle sample request; dac_data out 16 signed, sample; dac_valid out 1, one-cycle pulse.
REQ-009 SHALL have ports: underflow out 1, pulse; fifo_level out FIFO_AW+1, committed samples; pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt out 16 each.
REQ-010 Reset is rst_n, synchronous, active-low; clock is clk.

Function
REQ-011 SHALL treat a packet as the bytes delivered from a valid rising edge until valid falls; byte 0 is the first valid cycle.
REQ-012 SHALL parse big-endian: bytes 0-1 flags, bytes 2-3 sequence, 4-7 timestamp, 8-11 SSRC, byte 12 onward 16-bit samples (high byte first), in arrival order.
REQ-013 SHALL be a state machine IDLE -> HDR (bytes 0-11) -> PAYLOAD (bytes 12..UDP_LENGTH-1) -> IDLE; any check failure -> DISCARD until valid falls -> IDLE.
REQ-014 SHALL drop the packet if udp_rec_data_length != UDP_LENGTH, byte0[7:6] != 2, byte1[6:0] != PT_EXPECT, or (CHECK_SSRC and SSRC != SSRC_EXPECT).
REQ-015 SHALL, at the end of byte 11, drop the packet if free FIFO space < (UDP_LENGTH-12)/2 samples; no partial packet is ever written.
REQ-016 SHALL write payload samples tentatively; reader-visible writes take effect only when byte UDP_LENGTH-1 is accepted, the commit cycle.
REQ-017 SHALL roll back tentative writes and count a drop if valid falls before byte UDP_LENGTH-1 (truncation).
REQ-018 SHALL ignore bytes beyond UDP_LENGTH-1 while valid remains high, DISCARD without drop count.
REQ-019 SHALL increment pkt_ok_cnt on each commit and pkt_drop_cnt on each drop; all counters saturate at 16'hFFFF.
REQ-020 SHALL track the sequence of committed packets: after the first, if seq != (last_seq+1) mod 2**16, increment seq_gap_cnt; the packet is still accepted.
REQ-021 SHALL, on dac_req with fifo_level>0, pop one sample, drive dac_data with it, and pulse dac_valid on the next cycle (latency 1).
REQ-022 SHALL, on dac_req with fifo_level==0, drive dac_data=0 and pulse dac_valid and underflow on the next cycle.
REQ-023 SHALL handle a commit and a pop in the same cycle: fifo_level = old + (UDP_LENGTH-12)/2 - 1.
REQ-024 SHALL hold dac_data between requests.

Reset
REQ-025 SHALL on rst_n low set state IDLE, empty FIFO, all pointers 0, dac_data 0, dac_valid 0, underflow 0, counters 0, clear sequence history; a packet in flight is abandoned and uncounted.
REQ-026 SHALL, if rst_n releases while valid is high, stay in IDLE until valid falls, then accept the next packet.

Structure
REQ-027 SHALL take RTP_HEADER_LENGTH=12, RTP_VERSION=2, header byte offsets, and the default SSRC from shared package net_rtp_pkg, also used by the transmit packetizer.
REQ-028 SHALL place storage in sub-module rtp_sample_fifo: sync FIFO with tentative write pointer, committed write pointer, and commit/rollback inputs.

Verification
REQ-029 Valid packet (len 960, 0x80 0x80, seq 5, SSRC 0x12345678, samples 0x0001..0x01DA) -> fifo_level 474 after commit; 474 dac_req return 0x0001..0x01DA in order; pkt_ok_cnt=1.
REQ-030 Wrong SSRC 0xDEADBEEF, then len 958 -> fifo_level 0, pkt_drop_cnt=2; with CHECK_SSRC=0 the first packet is accepted.
REQ-031 Valid falls at byte 500 -> fifo_level stays 0, pkt_drop_cnt=1; the next full packet commits 474.
REQ-032 Seqs 0xFFFF, 0x0000, 0x0002 -> seq_gap_cnt=1 (gap only at 0x0002), with 0xFFFF->0x0000 wrap not a gap.
REQ-033 Three packets with no reads (FIFO 1024) -> the third is dropped at byte 11; dac_req on empty -> dac_data 0, underflow pulse.
REQ-034 rst_n asserted mid-payload -> all outputs 0; a packet started after release commits normally.
